// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 words x 32 bits.
// Define DCACHE_PERF_EN to add the hit_cnt/miss_cnt performance counters.
module dcache_direct_wb (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [7:0]   valid_q;
  logic [7:0]   dirty_q;
  logic [24:0]  tag_q  [8];
  logic [127:0] data_q [8];

  logic [2:0]   idx;
  logic [1:0]   offset;
  logic [24:0]  req_tag;
  logic         req;
  logic         hit;
  logic [127:0] line;
  logic [127:0] merged;
  logic         store_hit;
  logic         refill;

  assign idx     = proc_addr[4:2];
  assign offset  = proc_addr[1:0];
  assign req_tag = proc_addr[29:5];
  assign req     = proc_read | proc_write;
  assign line    = data_q[idx];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

  assign store_hit = (state_q == IDLE) && proc_write && hit;
  assign refill    = (state_q == ALLOCATE) && mem_ready;

  always_comb begin
    merged = line;
    merged[{offset, 5'd0} +: 32] = proc_wdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          if (valid_q[idx] && dirty_q[idx]) state_d = WRITEBACK;
          else                              state_d = ALLOCATE;
        end
      end
      WRITEBACK: if (mem_ready) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign proc_stall = (state_q != IDLE) || (req && !hit);
  assign proc_rdata = line[{offset, 5'd0} +: 32];
  assign mem_write  = (state_q == WRITEBACK);
  assign mem_read   = (state_q == ALLOCATE);
  // Writeback addresses the victim's block; refill addresses the requested block.
  assign mem_addr   = mem_write ? {tag_q[idx], idx} : proc_addr[29:2];
  assign mem_wdata  = line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (store_hit) begin
        data_q[idx]  <= merged;
        dirty_q[idx] <= 1'b1;
      end
      if (refill) begin
        data_q[idx]  <= mem_rdata;
        tag_q[idx]   <= req_tag;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE && req) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
